// File: rtl/retro_bram_loader.sv
// retro_bram_loader: packs a valid/ready byte stream little-endian into
// DataBusWidth-wide words and writes them to consecutive BRAM word addresses
// starting at a programmable base. Reports Busy/Done and a 16-bit byte sum.
module retro_bram_loader #(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 8,
    parameter int LengthWidth     = 20
) (
    input  logic                       Clk,
    input  logic                       nReset,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic [AddressBusWidth-1:0] BaseAddress,
    input  logic [LengthWidth-1:0]     Length,
    input  logic [7:0]                 InData,
    input  logic                       InValid,
    output logic                       InReady,
    output logic [AddressBusWidth-1:0] MemAddress,
    output logic [DataBusWidth-1:0]    MemWriteData,
    output logic                       MemWrite,
    input  logic                       MemReady,
    output logic                       Busy,
    output logic                       Done,
    output logic [15:0]                Checksum
);

    localparam int unsigned BPW       = DataBusWidth / 8;
    localparam int unsigned LaneWidth = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [LaneWidth-1:0] LastLane = LaneWidth'(BPW - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [LengthWidth-1:0] remaining_q;
    logic [LaneWidth-1:0]   lane_q;
    logic                   byte_hs;
    logic                   write_hs;
    logic                   start_ok;
    logic                   aborting;

    // Handshake strobes; stream and memory strobes depend on state only.
    always_comb begin
        InReady  = (state_q == COLLECT);
        MemWrite = (state_q == WRITE);
        byte_hs  = InReady && InValid;
        write_hs = MemWrite && MemReady;
        start_ok = (state_q == IDLE) && Start && !Abort;
        aborting = (state_q != IDLE) && Abort;
    end

    // Next-state selection; Abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_d = (Length == '0) ? FINISH : COLLECT;
                    end
                end
                COLLECT: begin
                    if (byte_hs && ((lane_q == LastLane) ||
                                    (remaining_q == LengthWidth'(1)))) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (write_hs) begin
                        state_d = (remaining_q == '0) ? FINISH : COLLECT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, packing datapath, address counter and status registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            lane_q       <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            Checksum     <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aborting) begin
                // A write completing on the abort edge still advances the
                // address; any partially packed word is dropped.
                Busy         <= 1'b0;
                lane_q       <= '0;
                MemWriteData <= '0;
                if (write_hs) begin
                    MemAddress <= MemAddress + AddressBusWidth'(1);
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            MemAddress   <= BaseAddress;
                            remaining_q  <= Length;
                            lane_q       <= '0;
                            MemWriteData <= '0;
                            Checksum     <= '0;
                            Done         <= 1'b0;
                            Busy         <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        if (byte_hs) begin
                            for (int unsigned i = 0; i < BPW; i++) begin
                                if (lane_q == LaneWidth'(i)) begin
                                    MemWriteData[8*i +: 8] <= InData;
                                end
                            end
                            Checksum    <= Checksum + {8'h00, InData};
                            remaining_q <= remaining_q - LengthWidth'(1);
                            lane_q      <= (lane_q == LastLane) ? '0 : lane_q + LaneWidth'(1);
                        end
                    end
                    WRITE: begin
                        if (write_hs) begin
                            MemAddress   <= MemAddress + AddressBusWidth'(1);
                            lane_q       <= '0;
                            MemWriteData <= '0;
                        end
                    end
                    default: begin
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_retro_bram_loader.sv
// Scoreboard bench for retro_bram_loader: one 8-bit-word and one 16-bit-word
// instance, expected writes queued by a byte-chunking model, checked by a
// negedge monitor as the DUTs emit them.
module tb_retro_bram_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start [2];
    logic        abort [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic        mem_write [2];
    logic        mem_ready [2];
    logic        busy [2];
    logic        done [2];
    logic [7:0]  in_data [2];
    logic [15:0] base [2];
    logic [15:0] mem_addr [2];
    logic [15:0] checksum [2];
    logic [19:0] len [2];
    logic [7:0]  mem_data0;
    logic [15:0] mem_data1;
    logic [63:0] mdata [2];

    assign mdata[0] = {56'd0, mem_data0};
    assign mdata[1] = {48'd0, mem_data1};

    wr_t         exp0[$];
    wr_t         exp1[$];
    logic [7:0]  stim [16];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          ready_force [2] = '{1'b1, 1'b1};
    bit          ready_rand = 1'b0;
    bit          stall_prev [2] = '{1'b0, 1'b0};
    logic [15:0] prev_a [2];
    logic [63:0] prev_d [2];

    retro_bram_loader #(.AddressBusWidth(16), .DataBusWidth(8), .LengthWidth(20)) u8 (
        .Clk(clk), .nReset(nReset), .Start(start[0]), .Abort(abort[0]),
        .BaseAddress(base[0]), .Length(len[0]), .InData(in_data[0]),
        .InValid(in_valid[0]), .InReady(in_ready[0]), .MemAddress(mem_addr[0]),
        .MemWriteData(mem_data0), .MemWrite(mem_write[0]), .MemReady(mem_ready[0]),
        .Busy(busy[0]), .Done(done[0]), .Checksum(checksum[0])
    );

    retro_bram_loader #(.AddressBusWidth(16), .DataBusWidth(16), .LengthWidth(20)) u16 (
        .Clk(clk), .nReset(nReset), .Start(start[1]), .Abort(abort[1]),
        .BaseAddress(base[1]), .Length(len[1]), .InData(in_data[1]),
        .InValid(in_valid[1]), .InReady(in_ready[1]), .MemAddress(mem_addr[1]),
        .MemWriteData(mem_data1), .MemWrite(mem_write[1]), .MemReady(mem_ready[1]),
        .Busy(busy[1]), .Done(done[1]), .Checksum(checksum[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // MemReady is changed just after the rising edge so it is stable at the negedge.
    initial begin
        mem_ready[0] = 1'b1;
        mem_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++)
                mem_ready[s] = ready_rand ? ($urandom_range(0, 2) != 0) : ready_force[s];
        end
    end

    task automatic mon(input int s);
        wr_t e;
        int  qs;
        if (!nReset) begin
            stall_prev[s] = 1'b0;
            return;
        end
        if (mem_write[s] && stall_prev[s]) begin
            chk($sformatf("stall_addr%0d", s), 64'(mem_addr[s]), 64'(prev_a[s]));
            chk($sformatf("stall_data%0d", s), mdata[s], prev_d[s]);
        end
        if (mem_write[s] && mem_ready[s]) begin
            qs = (s == 0) ? exp0.size() : exp1.size();
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write%0d: got addr %0h data %0h, required no write",
                         s, mem_addr[s], mdata[s]);
            end else begin
                e = (s == 0) ? exp0.pop_front() : exp1.pop_front();
                chk($sformatf("write_addr%0d", s), 64'(mem_addr[s]), 64'(e.a));
                chk($sformatf("write_data%0d", s), mdata[s], e.d);
            end
        end
        stall_prev[s] = mem_write[s] && !mem_ready[s];
        prev_a[s]     = mem_addr[s];
        prev_d[s]     = mdata[s];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Reference: the first n stim bytes cut into little-endian words at base, base+1, ...
    task automatic push_model(input int s, input logic [15:0] b, input int n);
        int  bpw;
        wr_t e;
        bpw = (s == 0) ? 1 : 2;
        for (int w = 0; w * bpw < n; w++) begin
            e.a = b + 16'(w);
            e.d = '0;
            for (int j = 0; j < bpw; j++)
                if (w * bpw + j < n) e.d[8*j +: 8] = stim[w * bpw + j];
            if (s == 0) exp0.push_back(e);
            else        exp1.push_back(e);
        end
    endtask

    function automatic logic [15:0] sum_bytes(input int n);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) acc = acc + 16'(stim[i]);
        return acc;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic chk_reset(input int s, input string tag);
        chk($sformatf("%s_in_ready%0d", tag, s), 64'(in_ready[s]), 64'd0);
        chk($sformatf("%s_mem_write%0d", tag, s), 64'(mem_write[s]), 64'd0);
        chk($sformatf("%s_busy%0d", tag, s), 64'(busy[s]), 64'd0);
        chk($sformatf("%s_done%0d", tag, s), 64'(done[s]), 64'd0);
        chk($sformatf("%s_addr%0d", tag, s), 64'(mem_addr[s]), 64'd0);
        chk($sformatf("%s_data%0d", tag, s), mdata[s], 64'd0);
        chk($sformatf("%s_checksum%0d", tag, s), 64'(checksum[s]), 64'd0);
    endtask

    task automatic start_load(input int s, input logic [15:0] b, input int n);
        start[s] = 1'b1;
        abort[s] = 1'b0;
        base[s]  = b;
        len[s]   = 20'(n);
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    // Offers stim bytes; with gaps, drops InValid and pulses a stray Start at random.
    task automatic feed(input int s, input int n, input bit gaps, output int fh);
        int i;
        int t;
        bit take;
        i  = 0;
        t  = 0;
        fh = -1;
        while (i < n && t < 400) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid[s] = 1'b0;
            end else begin
                in_valid[s] = 1'b1;
                in_data[s]  = stim[i];
            end
            start[s] = gaps && ($urandom_range(0, 7) == 0);
            if (start[s]) base[s] = 16'($urandom);
            take = in_valid[s] && in_ready[s];
            if (take && fh < 0) fh = cyc + 1;
            @(negedge clk);
            if (take) i++;
            t++;
        end
        in_valid[s] = 1'b0;
        start[s]    = 1'b0;
        chk($sformatf("feed_count%0d", s), 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int s, output int dc, output int bc);
        int t;
        t  = 0;
        bc = 0;
        while (!done[s] && t < 200) begin
            if (busy[s]) bc++;
            @(negedge clk);
            t++;
        end
        dc = cyc;
        chk($sformatf("done_seen%0d", s), 64'(done[s]), 64'd1);
    endtask

    task automatic run_load(input int s, input logic [15:0] b, input int n, input bit gaps,
                            output int fh, output int dc, output int bc);
        push_model(s, b, n);
        start_load(s, b, n);
        feed(s, n, gaps, fh);
        wait_done(s, dc, bc);
        chk($sformatf("end_busy%0d", s), 64'(busy[s]), 64'd0);
        chk($sformatf("end_checksum%0d", s), 64'(checksum[s]), 64'(sum_bytes(n)));
        chk($sformatf("end_pending_writes%0d", s), 64'(qsize(s)), 64'd0);
    endtask

    initial begin
        int fh, dc, bc, fh2, dc2, bc2, t, s, n;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; in_valid[k] = 1'b0;
            in_data[k] = '0; base[k] = '0; len[k] = '0;
        end
        repeat (2) @(negedge clk);
        chk_reset(0, "reset");
        chk_reset(1, "reset");
        nReset = 1'b1;
        @(negedge clk);

        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        run_load(0, 16'h0100, 4, 1'b0, fh, dc, bc);
        chk("tp1_latency", 64'(dc - fh), 64'd8);
        chk("tp1_checksum", 64'(checksum[0]), 64'h00AA);

        stim[0] = 8'hAB; stim[1] = 8'hCD; stim[2] = 8'hEF;
        run_load(1, 16'h0040, 3, 1'b0, fh, dc, bc);
        chk("tp2_checksum", 64'(checksum[1]), 64'h0267);

        run_load(0, 16'h0055, 0, 1'b0, fh, dc, bc);
        chk("len0_busy_cycles", 64'(bc), 64'd1);

        stim[0] = 8'h5A; stim[1] = 8'hA5;
        run_load(0, 16'hFFFF, 2, 1'b0, fh, dc, bc);
        chk("wrap_addr_after", 64'(mem_addr[0]), 64'h0001);

        stim[0] = 8'($urandom);
        ready_force[0] = 1'b0;
        fork
            run_load(0, 16'h0200, 1, 1'b0, fh, dc, bc);
            begin
                t = 0;
                while (!mem_write[0] && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 3; k++) begin
                    chk("stall_mem_write", 64'(mem_write[0]), 64'd1);
                    chk("stall_in_ready", 64'(in_ready[0]), 64'd0);
                    chk("stall_hold_addr", 64'(mem_addr[0]), 64'h0200);
                    chk("stall_hold_data", mdata[0], 64'(stim[0]));
                    if (k < 2) @(negedge clk);
                end
                ready_force[0] = 1'b1;
            end
        join

        for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
        push_model(1, 16'h0300, 4);
        start_load(1, 16'h0300, 8);
        feed(1, 5, 1'b0, fh);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        chk("abort_busy", 64'(busy[1]), 64'd0);
        chk("abort_done", 64'(done[1]), 64'd0);
        chk("abort_checksum", 64'(checksum[1]), 64'(sum_bytes(5)));
        chk("abort_pending_writes", 64'(qsize(1)), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_write", 64'(mem_write[1]), 64'd0);
        for (int i = 0; i < 5; i++) stim[i] = 8'($urandom);
        run_load(1, 16'h0310, 5, 1'b0, fh2, dc2, bc2);

        start[0] = 1'b1; abort[0] = 1'b1; base[0] = 16'h1234; len[0] = 20'd5;
        @(negedge clk);
        start[0] = 1'b0; abort[0] = 1'b0;
        chk("start_abort_busy", 64'(busy[0]), 64'd0);
        chk("start_abort_done_held", 64'(done[0]), 64'd1);
        chk("start_abort_in_ready", 64'(in_ready[0]), 64'd0);
        repeat (2) @(negedge clk);
        chk("start_abort_still_idle", 64'(busy[0]), 64'd0);

        ready_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            s = r % 2;
            n = $urandom_range(0, 11);
            for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
            run_load(s, 16'($urandom), n, 1'b1, fh, dc, bc);
        end
        ready_rand = 1'b0;
        repeat (2) @(negedge clk);

        stim[0] = 8'($urandom);
        start_load(1, 16'h0400, 6);
        feed(1, 1, 1'b0, fh);
        #2 nReset = 1'b0;
        #1 chk_reset(1, "midreset");
        @(negedge clk);
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_busy", 64'(busy[1]), 64'd0);
        chk("after_reset_no_write", 64'(mem_write[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
